// File: rtl/montgomery_digit_serial.sv
// Digit-serial Montgomery reduction: result = x * 2^-DATA_W mod m, one DIGIT_W-bit digit retired per cycle.
// Define MONT_OPERAND_CHECK_EN to flag even moduli and out-of-range x at accept time.
module montgomery_digit_serial #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned DIGIT_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [2*DATA_W-1:0]   x_i,
  input  logic [DATA_W-1:0]     m_i,
  input  logic [DIGIT_W-1:0]    minv_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_W-1:0]     result_o,
  output logic                  err_o
);

  // N iterations; R = 2^DATA_W is never materialised, it is the total shift over N iterations.
  localparam int unsigned N     = DATA_W / DIGIT_W;
  localparam int unsigned T_W   = 2 * DATA_W + 1;
  localparam int unsigned SUM_W = 2 * DATA_W + DIGIT_W + 1;
  localparam int unsigned QM_W  = DATA_W + DIGIT_W;
  localparam int unsigned CNT_W = $clog2(N + 1);

  if (DATA_W % DIGIT_W != 0) begin : g_bad_digit
    $error("montgomery_digit_serial: DATA_W must be a multiple of DIGIT_W");
  end

  typedef enum logic [1:0] {IDLE, ITER, FINAL, DONE} state_e;

  state_e              state_q, state_d;
  logic [T_W-1:0]      t_q, t_d;
  logic [DATA_W-1:0]   m_q, m_d;
  logic [DIGIT_W-1:0]  minv_q, minv_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [DIGIT_W-1:0]  q;
  logic [QM_W-1:0]     qm;
  logic                accept;
  logic                last_iter;
  logic                operand_err;

  assign accept    = in_valid_i && in_ready_o;
  assign last_iter = (cnt_q == CNT_W'(N - 1));

`ifdef MONT_OPERAND_CHECK_EN
  logic err_q, err_d;
  // x >= m*R is equivalent to the upper half of x being >= m.
  assign operand_err = !m_i[0] || (x_i[2*DATA_W-1:DATA_W] >= m_i);
  assign err_o       = err_q;
`else
  assign operand_err = 1'b0;
  assign err_o       = 1'b0;
`endif

  // State register and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      t_q      <= '0;
      m_q      <= '0;
      minv_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
`ifdef MONT_OPERAND_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      m_q      <= m_d;
      minv_q   <= minv_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
`ifdef MONT_OPERAND_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = operand_err ? DONE : ITER;
      ITER:  if (last_iter) state_d = FINAL;
      FINAL: state_d = DONE;
      DONE:  if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    t_d      = t_q;
    m_d      = m_q;
    minv_d   = minv_q;
    cnt_d    = cnt_q;
    result_d = result_q;
`ifdef MONT_OPERAND_CHECK_EN
    err_d    = err_q;
`endif
    q  = t_q[DIGIT_W-1:0] * minv_q;
    qm = QM_W'(q) * QM_W'(m_q);
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          t_d      = {1'b0, x_i};
          m_d      = m_i;
          minv_d   = minv_i;
          cnt_d    = '0;
          result_d = '0;
`ifdef MONT_OPERAND_CHECK_EN
          err_d    = operand_err;
`endif
        end
      end
      ITER: begin
        // Full-width sum before the shift; the low digit is zero by choice of q.
        t_d   = T_W'((SUM_W'(t_q) + SUM_W'(qm)) >> DIGIT_W);
        cnt_d = cnt_q + CNT_W'(1);
      end
      FINAL: begin
        result_d = (t_q >= T_W'(m_q)) ? DATA_W'(t_q - T_W'(m_q)) : t_q[DATA_W-1:0];
      end
      DONE: begin
        if (out_ready_i) begin
          result_d = '0;
`ifdef MONT_OPERAND_CHECK_EN
          err_d    = 1'b0;
`endif
        end
      end
      default: ;
    endcase
  end

  // Output logic; result_q is only non-zero while in DONE.
  always_comb begin
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == DONE);
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_montgomery_digit_serial.sv
// Directed bench for montgomery_digit_serial at DATA_W=8, DIGIT_W=2, m=13, m'=3.
// Latency is counted with the accepting cycle as cycle 0.
module tb_montgomery_digit_serial;

  localparam int DATA_W  = 8;
  localparam int DIGIT_W = 2;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [2*DATA_W-1:0]  x_i;
  logic [DATA_W-1:0]    m_i;
  logic [DIGIT_W-1:0]   minv_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [DATA_W-1:0]    result_o;
  logic                 err_o;

  int n_vec = 0;
  int n_err = 0;

  montgomery_digit_serial #(.DATA_W(DATA_W), .DIGIT_W(DIGIT_W)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .x_i         (x_i),
    .m_i         (m_i),
    .minv_i      (minv_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Waits (bounded) for IDLE, presents one operand set and returns just after the accepting edge.
  task automatic start(input string tag, input logic [15:0] x, input logic [7:0] m);
    int k = 0;
    while (!in_ready_o && k < 40) begin
      tick();
      k++;
    end
    check({tag, "_ready_before"}, in_ready_o, 1);
    x_i        = x;
    m_i        = m;
    minv_i     = 2'd3;
    in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    // Scramble operands mid-operation; they must be ignored.
    x_i        = ~x;
    m_i        = ~m;
    minv_i     = 2'd0;
  endtask

  // Called just after the accepting edge; counts cycles until out_valid_o.
  task automatic wait_result(input string tag, input int exp_lat, input bit chk_res,
                             input logic [7:0] exp_res, input logic exp_err);
    int n = 0;
    bit ready_seen = 1'b0;
    while (!out_valid_o && n < 40) begin
      if (in_ready_o) ready_seen = 1'b1;
      tick();
      n++;
    end
    check({tag, "_busy_ready_low"}, ready_seen, 0);
    check({tag, "_latency"}, n + 1, exp_lat);
    if (chk_res) check({tag, "_result"}, result_o, exp_res);
    check({tag, "_err"}, err_o, exp_err);
    check({tag, "_done_ready_low"}, in_ready_o, 0);
  endtask

  task automatic consume(input string tag);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check({tag, "_valid_cleared"}, out_valid_o, 0);
    check({tag, "_result_cleared"}, result_o, 0);
    check({tag, "_ready_back"}, in_ready_o, 1);
  endtask

  initial begin
    logic [15:0] xv [4];
    logic [7:0]  ev [4];
    bit          valid_seen;
    xv[0] = 16'd1280; ev[0] = 8'd5;
    xv[1] = 16'd1;    ev[1] = 8'd3;
    xv[2] = 16'd0;    ev[2] = 8'd0;
    xv[3] = 16'd3327; ev[3] = 8'd10;

    rst_ni      = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    x_i         = '0;
    m_i         = 8'd13;
    minv_i      = 2'd3;
    tick();
    tick();
    check("rst_ready", in_ready_o, 1);
    check("rst_valid", out_valid_o, 0);
    check("rst_result", result_o, 0);
    check("rst_err", err_o, 0);
    rst_ni = 1'b1;
    tick();

    // Directed reductions including x = m*R-1.
    for (int i = 0; i < 4; i++) begin
      start($sformatf("vec%0d", i), xv[i], 8'd13);
      wait_result($sformatf("vec%0d", i), 6, 1'b1, ev[i], 1'b0);
      consume($sformatf("vec%0d", i));
    end

    // Consumer stall for 5 cycles with a new operand set already waiting.
    start("stall", 16'd1280, 8'd13);
    wait_result("stall", 6, 1'b1, 8'd5, 1'b0);
    x_i        = 16'd1;
    m_i        = 8'd13;
    minv_i     = 2'd3;
    in_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall_hold_valid%0d", i), out_valid_o, 1);
      check($sformatf("stall_hold_result%0d", i), result_o, 5);
      check($sformatf("stall_hold_ready%0d", i), in_ready_o, 0);
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    check("stall_consumed_valid", out_valid_o, 0);
    check("stall_consumed_ready", in_ready_o, 1);
    tick();
    in_valid_i = 1'b0;
    wait_result("stall_next", 6, 1'b1, 8'd3, 1'b0);
    consume("stall_next");

    // Back-to-back: in_valid_i held high, out_ready_i high.
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    m_i         = 8'd13;
    minv_i      = 2'd3;
    x_i         = 16'd0;
    tick();
    x_i = 16'd3327;
    wait_result("b2b0", 6, 1'b1, 8'd0, 1'b0);
    tick();
    check("b2b0_ready_after", in_ready_o, 1);
    tick();
    x_i = 16'd1280;
    wait_result("b2b1", 6, 1'b1, 8'd10, 1'b0);
    tick();
    check("b2b1_ready_after", in_ready_o, 1);
    tick();
    in_valid_i = 1'b0;
    wait_result("b2b2", 6, 1'b1, 8'd5, 1'b0);
    tick();
    out_ready_i = 1'b0;
    check("b2b2_valid_cleared", out_valid_o, 0);
    check("b2b2_ready_after", in_ready_o, 1);

    // Reset pulse during the second ITER cycle aborts the operation.
    start("abort", 16'd1280, 8'd13);
    tick();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    check("abort_valid", out_valid_o, 0);
    check("abort_ready", in_ready_o, 1);
    valid_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid_o) valid_seen = 1'b1;
    end
    check("abort_no_result", valid_seen, 0);
    start("after_abort", 16'd1280, 8'd13);
    wait_result("after_abort", 6, 1'b1, 8'd5, 1'b0);
    consume("after_abort");

    // Illegal operands: even modulus and x = m*R.
`ifdef MONT_OPERAND_CHECK_EN
    start("even_m", 16'd1280, 8'd12);
    wait_result("even_m", 1, 1'b1, 8'd0, 1'b1);
    consume("even_m");
    start("x_range", 16'd3328, 8'd13);
    wait_result("x_range", 1, 1'b1, 8'd0, 1'b1);
    consume("x_range");
`else
    start("even_m", 16'd1280, 8'd12);
    wait_result("even_m", 6, 1'b0, 8'd0, 1'b0);
    consume("even_m");
    start("x_range", 16'd3328, 8'd13);
    wait_result("x_range", 6, 1'b0, 8'd0, 1'b0);
    consume("x_range");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
